// File: rtl/mem_arbiter_if.sv
// Requester-side bus for the memory arbiter.
// One instance per port: CPU and loader.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer
// for the single-port main memory.
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot,
    mem_arbiter_if.slave      cpu,
    mem_arbiter_if.slave      ld,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic             last_owner;
    logic [CNT_W-1:0] cnt;

    logic cpu_el;
    logic ld_el;
    logic any_el;
    logic gnt_ld;

    assign cpu_el = cpu.req & ~boot;
    assign ld_el  = ld.req;
    assign any_el = cpu_el | ld_el;
    // On a tie the port that did not own the last transaction wins.
    assign gnt_ld = ld_el & (~cpu_el | ~last_owner);

    assign cpu_hold = boot | (cpu.req & ~cpu.ack);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            cnt        <= '0;
            owner      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            cpu.ack    <= 1'b0;
            ld.ack     <= 1'b0;
            cpu.rdata  <= '0;
            ld.rdata   <= '0;
        end else begin
            cpu.ack <= 1'b0;
            ld.ack  <= 1'b0;
            unique case (state)
                IDLE: begin
                    // mem_* registers double as the latched request.
                    if (any_el) begin
                        owner     <= gnt_ld;
                        mem_addr  <= gnt_ld ? ld.addr : cpu.addr;
                        mem_wdata <= gnt_ld ? ld.wdata : cpu.wdata;
                        mem_we    <= gnt_ld ? ld.we : cpu.we;
                        mem_re    <= gnt_ld ? ~ld.we : ~cpu.we;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_re    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wdata <= '0;
                    if (mem_we) begin
                        mem_addr <= '0;
                        cpu.ack  <= ~owner;
                        ld.ack   <= owner;
                        state    <= DONE;
                    end else begin
                        cnt   <= CNT_W'(MEM_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        if (owner) begin
                            ld.rdata <= mem_rdata;
                        end else begin
                            cpu.rdata <= mem_rdata;
                        end
                        cpu.ack  <= ~owner;
                        ld.ack   <= owner;
                        mem_addr <= '0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one DUT with
// MEM_LAT=1, one with MEM_LAT=3, bench-side memories.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic boot;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) cpu_a ();
    mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) ld_a ();
    mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) cpu_b ();
    mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) ld_b ();

    logic [7:0]  ma_addr, mb_addr;
    logic [31:0] ma_wdata, mb_wdata;
    logic        ma_re, mb_re;
    logic        ma_we, mb_we;
    logic [31:0] ma_rdata, mb_rdata;
    logic        hold_a, hold_b;
    logic        busy_a, busy_b;
    logic        owner_a, owner_b;

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .boot      (boot),
        .cpu       (cpu_a),
        .ld        (ld_a),
        .cpu_hold  (hold_a),
        .mem_addr  (ma_addr),
        .mem_wdata (ma_wdata),
        .mem_re    (ma_re),
        .mem_we    (ma_we),
        .mem_rdata (ma_rdata),
        .busy      (busy_a),
        .owner     (owner_a)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .boot      (1'b0),
        .cpu       (cpu_b),
        .ld        (ld_b),
        .cpu_hold  (hold_b),
        .mem_addr  (mb_addr),
        .mem_wdata (mb_wdata),
        .mem_re    (mb_re),
        .mem_we    (mb_we),
        .mem_rdata (mb_rdata),
        .busy      (busy_b),
        .owner     (owner_b)
    );

    // Memories: read data appears MEM_LAT cycles after mem_re.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;
    logic [31:0] pb0, pb1;

    always @(posedge clk) begin
        if (bd_we) mem_a[bd_addr] <= bd_data;
        else if (ma_we) mem_a[ma_addr] <= ma_wdata;
        ma_rdata <= ma_re ? mem_a[ma_addr] : 32'h0;
    end

    always @(posedge clk) begin
        if (bd_we) mem_b[bd_addr] <= bd_data;
        else if (mb_we) mem_b[mb_addr] <= mb_wdata;
        pb0      <= mb_re ? mem_b[mb_addr] : 32'h0;
        pb1      <= pb0;
        mb_rdata <= pb1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n, k, la, ca, hl;

    initial begin
        reset = 1'b1;
        boot  = 1'b0;
        bd_we = 1'b0;
        bd_addr = 8'h0;
        bd_data = 32'h0;
        cpu_a.req = 0; cpu_a.we = 0;
        cpu_a.addr = 0; cpu_a.wdata = 0;
        ld_a.req = 0; ld_a.we = 0;
        ld_a.addr = 0; ld_a.wdata = 0;
        cpu_b.req = 0; cpu_b.we = 0;
        cpu_b.addr = 0; cpu_b.wdata = 0;
        ld_b.req = 0; ld_b.we = 0;
        ld_b.addr = 0; ld_b.wdata = 0;

        // Reset and memory preload.
        tick();
        bd_we = 1'b1;
        bd_addr = 8'h10; bd_data = 32'hDEADBEEF;
        tick();
        bd_addr = 8'hFF; bd_data = 32'hCAFEF00D;
        tick();
        bd_we = 1'b0;
        tick();
        chk("rst_busy", busy_a, 0);
        chk("rst_owner", owner_a, 0);
        chk("rst_ack", cpu_a.ack, 0);
        chk("rst_rdata", cpu_a.rdata, 0);
        chk("rst_re", ma_re, 0);
        chk("rst_addr", ma_addr, 0);
        chk("rst_hold", hold_a, 0);
        reset = 1'b0;
        tick();

        // CPU read of 0x10.
        cpu_a.req = 1; cpu_a.we = 0; cpu_a.addr = 8'h10;
        #1;
        chk("rd_hold_t0", hold_a, 1);
        tick();
        chk("rd_re_t1", ma_re, 1);
        chk("rd_we_t1", ma_we, 0);
        chk("rd_addr_t1", ma_addr, 8'h10);
        chk("rd_hold_t1", hold_a, 1);
        tick();
        chk("rd_re_t2", ma_re, 0);
        chk("rd_addr_t2", ma_addr, 8'h10);
        chk("rd_ack_t2", cpu_a.ack, 0);
        chk("rd_hold_t2", hold_a, 1);
        tick();
        chk("rd_ack_t3", cpu_a.ack, 1);
        chk("rd_data_t3", cpu_a.rdata, 32'hDEADBEEF);
        chk("rd_hold_t3", hold_a, 0);
        chk("rd_addr_t3", ma_addr, 0);
        cpu_a.req = 0;
        tick();
        chk("rd_ack_t4", cpu_a.ack, 0);
        chk("rd_busy_t4", busy_a, 0);
        chk("rd_keep_t4", cpu_a.rdata, 32'hDEADBEEF);

        // Loader write 0x05; inputs change after grant.
        ld_a.req = 1; ld_a.we = 1;
        ld_a.addr = 8'h05; ld_a.wdata = 32'h1234;
        tick();
        chk("wr_we_t1", ma_we, 1);
        chk("wr_re_t1", ma_re, 0);
        chk("wr_addr_t1", ma_addr, 8'h05);
        chk("wr_wdata_t1", ma_wdata, 32'h1234);
        chk("wr_owner_t1", owner_a, 1);
        ld_a.addr = 8'h77; ld_a.wdata = 32'h0;
        tick();
        chk("wr_ack_t2", ld_a.ack, 1);
        chk("wr_cpuack_t2", cpu_a.ack, 0);
        chk("wr_we_t2", ma_we, 0);
        ld_a.req = 0;
        tick();
        chk("wr_ack_t3", ld_a.ack, 0);

        // CPU reads back 0x05.
        cpu_a.req = 1; cpu_a.we = 0; cpu_a.addr = 8'h05;
        n = 0;
        while (!cpu_a.ack && n < 10) begin
            tick();
            n++;
        end
        chk("rb_lat", n, 3);
        chk("rb_data", cpu_a.rdata, 32'h1234);
        cpu_a.req = 0;
        tick();

        // Round robin from reset with both held.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_a.req = 1; cpu_a.we = 0; cpu_a.addr = 8'h10;
        ld_a.req = 1; ld_a.we = 0; ld_a.addr = 8'h05;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            tick();
            if (cpu_a.ack || ld_a.ack) begin
                chk("rr_ack", {cpu_a.ack, ld_a.ack},
                    (k % 2 == 0) ? 2'b10 : 2'b01);
                chk("rr_owner", owner_a, k % 2);
                if (k % 2 == 0)
                    chk("rr_cdata", cpu_a.rdata, 32'hDEADBEEF);
                else
                    chk("rr_ldata", ld_a.rdata, 32'h1234);
                k++;
            end
        end
        chk("rr_count", k, 4);
        cpu_a.req = 0;
        ld_a.req = 0;
        tick();

        // Boot: only loader is served.
        boot = 1;
        cpu_a.req = 1;
        ld_a.req = 1;
        la = 0; ca = 0; hl = 0;
        for (int i = 0; i < 20 && la < 3; i++) begin
            tick();
            if (cpu_a.ack) ca++;
            if (ld_a.ack) la++;
            if (!hold_a) hl++;
        end
        chk("boot_ld_acks", la, 3);
        chk("boot_cpu_acks", ca, 0);
        chk("boot_hold_low", hl, 0);
        boot = 0;
        tick();
        chk("boot_idle", busy_a, 0);
        tick();
        chk("boot_owner", owner_a, 0);
        chk("boot_re", ma_re, 1);
        chk("boot_addr", ma_addr, 8'h10);
        n = 0;
        while (!cpu_a.ack && n < 10) begin
            tick();
            n++;
        end
        chk("boot_cpu_lat", n, 2);
        chk("boot_cpu_data", cpu_a.rdata, 32'hDEADBEEF);
        cpu_a.req = 0;
        ld_a.req = 0;
        tick();

        // Reset during WAIT drops the read.
        cpu_a.req = 1; cpu_a.addr = 8'h10;
        tick();
        tick();
        chk("rw_wait_busy", busy_a, 1);
        chk("rw_wait_addr", ma_addr, 8'h10);
        reset = 1;
        tick();
        chk("rw_busy", busy_a, 0);
        chk("rw_ack", cpu_a.ack, 0);
        chk("rw_rdata", cpu_a.rdata, 0);
        chk("rw_re", ma_re, 0);
        reset = 0;
        cpu_a.req = 0;
        tick();
        chk("rw_ack_after", cpu_a.ack, 0);

        // MEM_LAT=3 read of 0xFF.
        cpu_b.req = 1; cpu_b.we = 0; cpu_b.addr = 8'hFF;
        tick();
        chk("l3_re_t1", mb_re, 1);
        chk("l3_addr_t1", mb_addr, 8'hFF);
        tick();
        chk("l3_re_t2", mb_re, 0);
        chk("l3_addr_t2", mb_addr, 8'hFF);
        chk("l3_ack_t2", cpu_b.ack, 0);
        tick();
        chk("l3_addr_t3", mb_addr, 8'hFF);
        chk("l3_ack_t3", cpu_b.ack, 0);
        tick();
        chk("l3_addr_t4", mb_addr, 8'hFF);
        chk("l3_ack_t4", cpu_b.ack, 0);
        chk("l3_hold_t4", hold_b, 1);
        tick();
        chk("l3_ack_t5", cpu_b.ack, 1);
        chk("l3_data_t5", cpu_b.rdata, 32'hCAFEF00D);
        chk("l3_addr_t5", mb_addr, 0);
        chk("l3_hold_t5", hold_b, 0);
        chk("l3_ldack_t5", ld_b.ack, 0);
        cpu_b.req = 0;
        tick();
        chk("l3_busy_t6", busy_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the single-port main memory.
- Port 0 (cpu_*) is driven by the multicycle CPU for fetch, LW and SW. Port 1 (ld_*) is driven by the program loader and debug reader.
- Serialises requests with round-robin fairness, latches address and data, sequences memory read latency, and returns a one-cycle ack per transaction.
- Produces cpu_hold, which freezes the CPU control FSM while the CPU's access is pending or while boot is high.

Parameters:
- ADDR_W, 8: memory address width.
- DATA_W, 32: memory word width.
- MEM_LAT, 1: cycles from the mem_re cycle until mem_rdata is valid; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- boot  in  1  loader-exclusive mode: port 0 is never granted while high.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid from cpu_ack until the next CPU read completes.
- cpu_hold  out  1  stall to the CPU control FSM.
- ld_req  in  1  loader request; held until ld_ack.
- ld_we  in  1  1 = write, 0 = read.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_ack  out  1  one-cycle completion pulse.
- ld_rdata  out  DATA_W  loader read data, same validity rule as cpu_rdata.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.
- owner  out  1  port owning the current transaction (0 = CPU, 1 = loader).

Behaviour:
- Reset:
  - Synchronous, active-high; clk and reset are the only clock/reset.
  - State goes to IDLE. last_owner = 1, so the CPU wins the first tie. Wait counter = 0.
  - All outputs are 0, including rdata registers and owner.
  - A transaction in flight is dropped with no ack.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Eligible requests: cpu_req & ~boot, and ld_req.
  - Only one eligible: grant it.
  - Both eligible: grant the port != last_owner.
  - On a grant: latch addr, wdata, we and owner into internal registers, then go to ACCESS.
  - No eligible request: stay in IDLE.
- ACCESS (1 cycle):
  - mem_addr and mem_wdata come from the latched registers.
  - Write: mem_we = 1, next state DONE.
  - Read: mem_re = 1, wait counter loaded with MEM_LAT, next state WAIT.
- WAIT:
  - mem_addr is held and the counter decrements each cycle.
  - In the cycle the counter reaches 1, mem_rdata is captured into the owner's rdata register, then go to DONE.
- DONE (1 cycle):
  - The owner's ack = 1.
  - last_owner <= owner.
  - Next state IDLE unconditionally.
- Latency, request sampled in IDLE at cycle T:
  - Write: mem_we at T+1, ack at T+2.
  - Read: mem_re at T+1, data captured at T+1+MEM_LAT, ack at T+2+MEM_LAT.
  - Minimum spacing is 3 cycles per write and 3+MEM_LAT cycles per read.
- Outside ACCESS and WAIT: mem_addr = 0, mem_wdata = 0, mem_re = 0, mem_we = 0. mem_re and mem_we are never both high.
- Requests and acks:
  - Requester inputs may change after grant; the latched values are used.
  - req dropped mid-transaction: the transaction still completes and ack still pulses.
  - req still high in the cycle after ack: treated as a new request.
- cpu_hold = boot | (cpu_req & ~cpu_ack), combinational. It is low in the ack cycle so the CPU advances exactly then.
- boot:
  - Rising mid-transaction on port 0: that transaction completes normally.
  - While boot is high, cpu_req never wins arbitration.
- The non-owner port's ack and rdata are unaffected by the other port's transactions.

Test Plan:
- Reset, then cpu_req=1, we=0, addr=8'h10, memory[0x10]=32'hDEADBEEF, MEM_LAT=1 -> mem_re at T+1 with mem_addr=8'h10; cpu_ack at T+3 with cpu_rdata=32'hDEADBEEF; cpu_hold high T..T+2 and low at T+3.
- ld_req write, addr=8'h05, wdata=32'h0000_1234 -> mem_we only at T+1 with mem_addr=8'h05; ld_ack at T+2; a subsequent CPU read of 8'h05 returns 32'h0000_1234.
- cpu_req and ld_req both held continuously for 4 transactions after reset -> grant order CPU, LD, CPU, LD; owner toggles; no ack ever lands on the idle port.
- boot=1 with cpu_req and ld_req high -> only ld transactions occur; cpu_hold stays 1. boot falls -> CPU is granted in the next IDLE.
- Reset asserted in WAIT of a CPU read -> next cycle state is IDLE, busy=0, no cpu_ack, cpu_rdata=0, mem_re=0.
- MEM_LAT=3 read of addr 8'hFF -> mem_re at T+1, capture at T+4, ack at T+5; mem_addr held at 8'hFF for T+1..T+4.
